// File: rtl/icache_direct_mapped.sv
// icache_direct_mapped
//
// Read-only, direct-mapped instruction cache between the core's I-cache port
// and instruction memory. Hits return data in the same cycle. A miss stalls
// the core while one 4-word (128-bit) line is refilled over a req/ready
// handshake. The cache never writes memory.
//
// Optional feature: define ICACHE_PERF_EN to add saturating hit/miss counters
// (hit_cnt, miss_cnt).
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   proc_read           fetch request; lookup this cycle
//   proc_write          ignored (core ties it 0)
//   proc_addr[29:0]     word address
//   proc_wdata[31:0]    ignored
//   proc_stall          1 = proc_rdata not valid; core holds proc_addr
//   proc_rdata[31:0]    fetched word
//   mem_read            line refill request
//   mem_write           constant 0
//   mem_addr[27:0]      line address of the miss
//   mem_wdata[127:0]    constant 0
//   mem_ready           1-cycle pulse; mem_rdata valid in that cycle
//   mem_rdata[127:0]    line data, word 0 in [31:0]
//   hit_cnt, miss_cnt   (ICACHE_PERF_EN only) saturating event counters

module icache_direct_mapped #(
  parameter int unsigned NUM_LINES = 8,
  parameter int unsigned IDX_W     = 3,
  parameter int unsigned TAG_W     = 28 - IDX_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           proc_read,
  input  logic           proc_write,
  input  logic [29:0]    proc_addr,
  input  logic [31:0]    proc_wdata,
  output logic           proc_stall,
  output logic [31:0]    proc_rdata,
  output logic           mem_read,
  output logic           mem_write,
  output logic [27:0]    mem_addr,
  output logic [127:0]   mem_wdata,
  input  logic           mem_ready,
  input  logic [127:0]   mem_rdata
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]    hit_cnt,
  output logic [31:0]    miss_cnt
`endif
);

  typedef enum logic [0:0] {StIdle, StAllocate} state_e;

  state_e                 state_q;
  logic [NUM_LINES-1:0]   valid_q;
  logic [TAG_W-1:0]       tag_q  [NUM_LINES];
  logic [127:0]           data_q [NUM_LINES];
  logic [27:0]            miss_addr_q;
  logic                   mem_read_q;

  logic [1:0]             offset;
  logic [IDX_W-1:0]       index;
  logic [TAG_W-1:0]       tag;
  logic [IDX_W-1:0]       miss_idx;
  logic [TAG_W-1:0]       miss_tag;
  logic [127:0]           line;
  logic                   hit;
  logic                   refill_done;

  assign offset   = proc_addr[1:0];
  assign index    = proc_addr[IDX_W+1:2];
  assign tag      = proc_addr[29:IDX_W+2];
  assign miss_idx = miss_addr_q[IDX_W-1:0];
  assign miss_tag = miss_addr_q[27:IDX_W];

  assign hit         = valid_q[index] && (tag_q[index] == tag);
  assign refill_done = (state_q == StAllocate) && mem_ready;

  // Write side is tied off; these inputs are intentionally unused.
  logic unused_inputs;
  assign unused_inputs = ^{proc_write, proc_wdata};

  // Controller: state, valid bits, latched miss address and refill request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      miss_addr_q <= '0;
      mem_read_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (proc_read && !hit) begin
            miss_addr_q <= proc_addr[29:2];
            mem_read_q  <= 1'b1;
            state_q     <= StAllocate;
          end
        end
        StAllocate: begin
          if (mem_ready) begin
            valid_q[miss_idx] <= 1'b1;
            mem_read_q        <= 1'b0;
            state_q           <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Tag/data arrays carry no reset; valid_q alone qualifies their contents.
  always_ff @(posedge clk) begin
    if (refill_done) begin
      data_q[miss_idx] <= mem_rdata;
      tag_q[miss_idx]  <= miss_tag;
    end
  end

  assign line = data_q[index];

  always_comb begin
    proc_rdata = line[31:0];
    unique case (offset)
      2'd0: proc_rdata = line[31:0];
      2'd1: proc_rdata = line[63:32];
      2'd2: proc_rdata = line[95:64];
      2'd3: proc_rdata = line[127:96];
      default: proc_rdata = line[31:0];
    endcase
  end

  // Stall is combinational so a miss is flagged in the cycle it is looked up.
  always_comb begin
    proc_stall = 1'b0;
    if (state_q == StAllocate) begin
      proc_stall = 1'b1;
    end else if (proc_read && !hit) begin
      proc_stall = 1'b1;
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_addr  = miss_addr_q;
  assign mem_write = 1'b0;
  assign mem_wdata = '0;

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q,  hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic        hit_evt, miss_evt;

  assign hit_evt  = (state_q == StIdle) && proc_read && hit;
  assign miss_evt = (state_q == StIdle) && proc_read && !hit;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit_evt && (hit_cnt_q != 32'hFFFF_FFFF)) begin
      hit_cnt_d = hit_cnt_q + 32'd1;
    end
    if (miss_evt && (miss_cnt_q != 32'hFFFF_FFFF)) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Self-checking bench for icache_direct_mapped. A behavioural memory supplies
// line data that is a pure function of the line address, so every fetched word
// has a known expected value independent of the cache state.

module tb_icache_direct_mapped;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           proc_read;
  logic           proc_write;
  logic [29:0]    proc_addr;
  logic [31:0]    proc_wdata;
  logic           proc_stall;
  logic [31:0]    proc_rdata;
  logic           mem_read;
  logic           mem_write;
  logic [27:0]    mem_addr;
  logic [127:0]   mem_wdata;
  logic           mem_ready;
  logic [127:0]   mem_rdata;
`ifdef ICACHE_PERF_EN
  logic [31:0]    hit_cnt;
  logic [31:0]    miss_cnt;
`endif

  always #5 clk = ~clk;

  icache_direct_mapped dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_stall (proc_stall),
    .proc_rdata (proc_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
`ifdef ICACHE_PERF_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [27:0] refill_q[$];
  int          mem_lat  = 0;
  bit          resp_en  = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Line word i = (0x11111111 * (i+1)) ^ (line_addr << 4); line 0 -> 1111.., 2222..
  function automatic logic [127:0] line_data(input logic [27:0] a);
    logic [127:0] d;
    for (int i = 0; i < 4; i++) begin
      d[i*32 +: 32] = (32'h1111_1111 * 32'(i + 1)) ^ {a, 4'h0};
    end
    return d;
  endfunction

  function automatic logic [31:0] word_of(input logic [29:0] a);
    logic [127:0] l;
    l = line_data(a[29:2]);
    return l[a[1:0]*32 +: 32];
  endfunction

  // Memory responder: pulses mem_ready mem_lat cycles into a refill request.
  initial begin
    int cnt;
    cnt       = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n || !resp_en) begin
        cnt = 0;
      end else if (mem_ready) begin
        mem_ready = 1'b0;
        cnt       = 0;
      end else if (mem_read) begin
        if (cnt >= mem_lat) begin
          mem_ready = 1'b1;
          mem_rdata = line_data(mem_addr);
          refill_q.push_back(mem_addr);
        end else begin
          cnt++;
        end
      end
    end
  end

  // Entered just after a rising edge; leaves just after a rising edge.
  task automatic fetch(input logic [29:0] a, input int exp_stall);
    int stalls;
    stalls    = 0;
    proc_read = 1'b1;
    proc_addr = a;
    exp_q.push_back(word_of(a));
    @(negedge clk);
    while (proc_stall && stalls < 200) begin
      if (stalls > 0) begin
        check("refill_mem_read", 32'(mem_read), 32'd1);
        check("refill_mem_addr", 32'(mem_addr), 32'(a[29:2]));
      end
      stalls++;
      @(negedge clk);
    end
    check("stall_cycles", stalls, exp_stall);
    if (exp_stall == 0) check("hit_mem_read", 32'(mem_read), 32'd0);
    check("rdata", proc_rdata, exp_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic check_refill(input logic [27:0] exp_addr);
    if (refill_q.size() == 0) begin
      check("refill_present", 32'd0, 32'd1);
    end else begin
      check("refill_addr", 32'(refill_q.pop_front()), 32'(exp_addr));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    proc_addr  = '0;
    proc_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_stall", 32'(proc_stall), 32'd0);
    check("reset_mem_read", 32'(mem_read), 32'd0);
    check("reset_mem_addr", 32'(mem_addr), 32'd0);
`ifdef ICACHE_PERF_EN
    check("reset_hit_cnt", hit_cnt, 32'd0);
    check("reset_miss_cnt", miss_cnt, 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Cold miss, memory answers 3 cycles late.
    mem_lat = 3;
    fetch(30'h1, 5);
    check_refill(28'h0);

    // Hits on the freshly filled line.
    mem_lat = 0;
    fetch(30'h0, 0);
    fetch(30'h2, 0);
    fetch(30'h3, 0);

    // Conflict eviction on index 0, then a different index.
    fetch(30'h20, 2);
    check_refill(28'h8);
    fetch(30'h0, 2);
    check_refill(28'h0);
    fetch(30'h5, 2);
    check_refill(28'h1);
    fetch(30'h1, 0);
    fetch(30'h6, 0);

    // Long latency refill.
    mem_lat = 20;
    fetch(30'h107, 22);
    check_refill(28'h41);
    mem_lat = 0;
    fetch(30'h104, 0);

    check("mem_write_zero", 32'(mem_write), 32'd0);
    check("mem_wdata_zero", 32'(|mem_wdata), 32'd0);

    // Reset in the middle of a refill, then a stray mem_ready.
    resp_en   = 1'b0;
    proc_read = 1'b1;
    proc_addr = 30'h40;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("alloc_mem_read", 32'(mem_read), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_mem_read", 32'(mem_read), 32'd0);
    proc_read = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mem_ready = 1'b1;
    mem_rdata = line_data(28'h10);
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    check("stray_ignored_mem_read", 32'(mem_read), 32'd0);
    resp_en = 1'b1;
    mem_lat = 0;
    refill_q.delete();
    fetch(30'h40, 2);
    check_refill(28'h10);
    fetch(30'h5, 2);
    check_refill(28'h1);

`ifdef ICACHE_PERF_EN
    proc_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("perf_rst_hit", hit_cnt, 32'd0);
    check("perf_rst_miss", miss_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    fetch(30'h9, 2);
    fetch(30'h8, 0);
    fetch(30'hA, 0);
    fetch(30'hB, 0);
    fetch(30'h9, 0);
    proc_read = 1'b0;
    @(negedge clk);
    check("perf_miss_cnt", miss_cnt, 32'd1);
    check("perf_hit_cnt", hit_cnt, 32'd5);
`endif

    proc_read = 1'b0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
